// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between instruction fetch (IF) and load/store (DM).
// DM has priority; a bounded DM grant streak guarantees IF forward progress.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  flush_i,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_W-1:0]     if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [DATA_W/8-1:0]   dm_be_i,
   input  logic [ADDR_W-1:0]     dm_addr_i,
   input  logic [DATA_W-1:0]     dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [DATA_W-1:0]     dm_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [DATA_W/8-1:0]   mem_be_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_W-1:0]     mem_rdata_i
);

   localparam int unsigned BE_W       = DATA_W / 8;
   localparam logic [3:0]  STREAK_MAX = 4'(MAX_DM_STREAK);

   typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_RESP} state_e;
   typedef enum logic {OWN_DM, OWN_IF} owner_e;

   state_e     state_q, state_d;
   owner_e     owner_q, owner_d;
   logic [3:0] streak_q, streak_d;
   logic       drop_q, drop_d;

   owner_e     sel_owner;
   owner_e     cur_owner;
   logic       req;
   logic       gnt;
   logic       rsp;
   logic       is_dm;

   always_comb begin
      // IF wins over a pending DM request only once the DM streak has saturated
      sel_owner = (dm_req_i && !(if_req_i && (streak_q == STREAK_MAX))) ? OWN_DM : OWN_IF;
      cur_owner = (state_q == S_IDLE) ? sel_owner : owner_q;
      req       = (state_q == S_IDLE) ? (if_req_i | dm_req_i) : (state_q == S_LOCKED);
      gnt       = req & mem_gnt_i;
      rsp       = (state_q == S_RESP) & mem_rvalid_i;
      is_dm     = (cur_owner == OWN_DM);
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      streak_d = streak_q;
      drop_d   = drop_q;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               owner_d = sel_owner;
               state_d = mem_gnt_i ? S_RESP : S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (mem_gnt_i) state_d = S_RESP;
         end
         S_RESP: begin
            if (mem_rvalid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // The response cycle always retires the drop flag, even if flush_i coincides
      if (rsp) begin
         drop_d = 1'b0;
      end else if (flush_i && (owner_q == OWN_IF) && (state_q != S_IDLE)) begin
         drop_d = 1'b1;
      end

      if (!if_req_i || (gnt && !is_dm)) begin
         streak_d = '0;
      end else if (gnt && is_dm && (streak_q != 4'hF)) begin
         streak_d = streak_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_DM;
         streak_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
         drop_q   <= drop_d;
      end
   end

   // Outputs are forced low while reset is asserted, including the pass-through paths
   always_comb begin
      mem_req_o   = rst_n_i & req;
      mem_we_o    = rst_n_i & is_dm & dm_we_i;
      mem_be_o    = {BE_W{rst_n_i}} & (is_dm ? dm_be_i : {BE_W{1'b1}});
      mem_addr_o  = {ADDR_W{rst_n_i}} & (is_dm ? dm_addr_i : if_addr_i);
      mem_wdata_o = {DATA_W{rst_n_i}} & (is_dm ? dm_wdata_i : '0);
      if_gnt_o    = rst_n_i & gnt & !is_dm;
      dm_gnt_o    = rst_n_i & gnt & is_dm;
      if_rvalid_o = rst_n_i & rsp & (owner_q == OWN_IF) & !drop_q;
      dm_rvalid_o = rst_n_i & rsp & (owner_q == OWN_DM);
      if_rdata_o  = {DATA_W{rst_n_i}} & mem_rdata_i;
      dm_rdata_o  = {DATA_W{rst_n_i}} & mem_rdata_i;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a memory responder,
// and a monitor that checks grants and responses against hand-computed expectations.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i = 1'b0;
   logic        dm_we_i = 1'b0;
   logic [3:0]  dm_be_i = '0;
   logic [31:0] dm_addr_i = '0;
   logic [31:0] dm_wdata_i = '0;
   logic        dm_gnt_o, dm_rvalid_o;
   logic [31:0] dm_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'h1234_5678;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
      .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {bit dm; bit we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} gnt_t;
   typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} dm_cmd_t;
   typedef struct {bit chk; logic [31:0] data;} rsp_t;

   gnt_t        exp_gnt[$];
   logic [31:0] exp_if_rd[$];
   rsp_t        exp_dm_rd[$];
   logic [31:0] if_cmd_q[$];
   dm_cmd_t     dm_cmd_q[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          gnt_wait = 0;
   bit          inject_rv = 1'b0;
   logic [31:0] mem [logic [31:0]];

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic eg_if(input logic [31:0] a);
      gnt_t g;
      g.dm = 1'b0; g.we = 1'b0; g.be = 4'hF; g.addr = a; g.wdata = '0;
      exp_gnt.push_back(g);
   endtask

   task automatic eg_dm(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
      gnt_t g;
      g.dm = 1'b1; g.we = we; g.be = be; g.addr = a; g.wdata = wd;
      exp_gnt.push_back(g);
   endtask

   task automatic issue_if(input logic [31:0] a, input logic [31:0] rd, input bit with_rsp);
      if_cmd_q.push_back(a);
      if (with_rsp) exp_if_rd.push_back(rd);
   endtask

   task automatic issue_dm(input bit we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd);
      dm_cmd_t c;
      rsp_t    r;
      c.we = we; c.be = be; c.addr = a; c.wdata = wd;
      r.chk = !we; r.data = rd;
      dm_cmd_q.push_back(c);
      exp_dm_rd.push_back(r);
      eg_dm(we, be, a, wd);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (exp_gnt.size() == 0 && exp_if_rd.size() == 0 && exp_dm_rd.size() == 0 &&
             if_cmd_q.size() == 0 && dm_cmd_q.size() == 0 && !if_req_i && !dm_req_i) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 1, 0);
      repeat (2) @(negedge clk_i);
   endtask

   task automatic wait_if_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (if_gnt_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("if_gnt_timeout", 1, 0);
   endtask

   // IF requester: holds request until granted, then presents the next queued fetch
   initial begin : if_driver
      bit done = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (!rst_n_i) begin
            if_req_i = 1'b0; done = 1'b0;
         end else begin
            if (done) begin if_req_i = 1'b0; done = 1'b0; end
            if (!if_req_i && if_cmd_q.size() > 0) begin
               if_addr_i = if_cmd_q.pop_front();
               if_req_i  = 1'b1;
            end
         end
         @(negedge clk_i);
         if (if_req_i && if_gnt_o) done = 1'b1;
      end
   end

   initial begin : dm_driver
      bit      done = 1'b0;
      dm_cmd_t c;
      forever begin
         @(posedge clk_i); #1;
         if (!rst_n_i) begin
            dm_req_i = 1'b0; done = 1'b0;
         end else begin
            if (done) begin dm_req_i = 1'b0; done = 1'b0; end
            if (!dm_req_i && dm_cmd_q.size() > 0) begin
               c = dm_cmd_q.pop_front();
               dm_we_i = c.we; dm_be_i = c.be; dm_addr_i = c.addr; dm_wdata_i = c.wdata;
               dm_req_i = 1'b1;
            end
         end
         @(negedge clk_i);
         if (dm_req_i && dm_gnt_o) done = 1'b1;
      end
   end

   // Memory: grant after gnt_wait requesting cycles, respond two cycles after grant
   initial begin : mem_model
      int          cnt = 0;
      int          pend = 0;
      logic [31:0] rdat = '0;
      logic [31:0] m;
      forever begin
         @(posedge clk_i); #2;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (!rst_n_i) begin
            cnt = 0; pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdat; end
            end
            if (inject_rv) begin mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; end
            if (mem_req_o) begin
               if (cnt == gnt_wait) begin
                  mem_gnt_i = 1'b1; cnt = 0; pend = 2;
                  m = mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
                  if (mem_we_o) begin
                     for (int b = 0; b < 4; b++)
                        if (mem_be_o[b]) m[8*b +: 8] = mem_wdata_o[8*b +: 8];
                     mem[mem_addr_o] = m;
                  end
                  rdat = m;
               end else begin
                  cnt++;
               end
            end
         end
      end
   end

   initial begin : monitor
      gnt_t        g;
      logic [31:0] d;
      rsp_t        r;
      forever begin
         @(negedge clk_i);
         if (rst_n_i) begin
            if (if_gnt_o || dm_gnt_o) begin
               if (exp_gnt.size() == 0) begin
                  chk("unexpected_gnt", {if_gnt_o, dm_gnt_o, mem_addr_o}, 0);
               end else begin
                  g = exp_gnt.pop_front();
                  chk("gnt_fields", {if_gnt_o, dm_gnt_o, mem_we_o, mem_be_o, mem_addr_o},
                      {!g.dm, g.dm, g.we, g.be, g.addr});
                  if (g.we) chk("gnt_wdata", mem_wdata_o, g.wdata);
               end
            end
            if (if_rvalid_o) begin
               if (exp_if_rd.size() == 0) chk("unexpected_if_rvalid", if_rdata_o, 0);
               else begin
                  d = exp_if_rd.pop_front();
                  chk("if_rdata", if_rdata_o, d);
               end
            end
            if (dm_rvalid_o) begin
               if (exp_dm_rd.size() == 0) chk("unexpected_dm_rvalid", dm_rdata_o, 0);
               else begin
                  r = exp_dm_rd.pop_front();
                  if (r.chk) chk("dm_rdata", dm_rdata_o, r.data);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bit ok;
      int gc, rc, gcyc, rcyc;

      mem[32'h100]  = 32'h0000_0013;
      mem[32'h104]  = 32'h0040_0093;
      mem[32'h108]  = 32'h0010_0113;
      mem[32'h10C]  = 32'h0020_8193;
      mem[32'h110]  = 32'h0031_0233;
      mem[32'h114]  = 32'hFFFF_FFFF;
      mem[32'h3000] = 32'hA0A0_A0A0;
      mem[32'h3004] = 32'hB0B0_B0B0;

      // Reset: every output low, including rdata pass-through
      repeat (2) @(negedge clk_i);
      chk("reset_outputs", {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                            mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
      @(posedge clk_i); #3 rst_n_i = 1'b1;
      @(negedge clk_i);

      // IF only: one grant cycle, response pulse two cycles later
      eg_if(32'h100); issue_if(32'h100, 32'h0000_0013, 1'b1);
      gc = 0; rc = 0; gcyc = 0; rcyc = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         if (if_gnt_o) begin gc++; gcyc = k; end
         if (if_rvalid_o) begin rc++; rcyc = k; end
      end
      chk("if_gnt_cycles", gc, 1);
      chk("if_rvalid_cycles", rc, 1);
      chk("if_rvalid_latency", rcyc - gcyc, 2);
      wait_idle();

      // Simultaneous requests: DM write first, IF next
      issue_dm(1'b1, 4'hF, 32'h2000, 32'hCAFE_F00D, '0);
      eg_if(32'h104); issue_if(32'h104, 32'h0040_0093, 1'b1);
      wait_idle();

      // Streak: four DM grants, then IF, four more DM, then IF again
      issue_dm(1'b1, 4'h3, 32'h2000, 32'h1111_2222, '0);
      issue_dm(1'b0, 4'hF, 32'h2000, '0, 32'hCAFE_2222);
      issue_dm(1'b1, 4'hF, 32'h2004, 32'h0000_0055, '0);
      issue_dm(1'b0, 4'hF, 32'h2004, '0, 32'h0000_0055);
      eg_if(32'h108); issue_if(32'h108, 32'h0010_0113, 1'b1);
      issue_dm(1'b0, 4'hF, 32'h3000, '0, 32'hA0A0_A0A0);
      issue_dm(1'b0, 4'hF, 32'h3004, '0, 32'hB0B0_B0B0);
      issue_dm(1'b1, 4'hC, 32'h3000, 32'h1234_5678, '0);
      issue_dm(1'b0, 4'hF, 32'h3000, '0, 32'h1234_A0A0);
      eg_if(32'h10C); issue_if(32'h10C, 32'h0020_8193, 1'b1);
      wait_idle();

      // Stalled IF grant: address held in LOCKED while DM arrives, DM served afterwards
      gnt_wait = 3;
      eg_if(32'h110); issue_if(32'h110, 32'h0031_0233, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         if (k == 0) issue_dm(1'b0, 4'hF, 32'h2004, '0, 32'h0000_0055);
         chk("locked_req_addr", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 1'b0, 4'hF, 32'h110});
         chk("locked_gnt", {if_gnt_o, dm_gnt_o}, (k == 3) ? 2'b10 : 2'b00);
      end
      wait_idle();
      gnt_wait = 0;

      // Flush during IF RESP: response dropped, pending DM issued right after
      eg_if(32'h114); issue_if(32'h114, '0, 1'b0);
      wait_if_gnt(ok);
      issue_dm(1'b0, 4'hF, 32'h3004, '0, 32'hB0B0_B0B0);
      @(posedge clk_i); #1 flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_resp_noreq", mem_req_o, 0);
      @(posedge clk_i); #1 flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_rvalid_cycle", {if_rvalid_o, dm_gnt_o}, 2'b00);
      @(negedge clk_i);
      chk("flush_dm_issue", {mem_req_o, dm_gnt_o}, 2'b11);
      wait_idle();

      // Reset during RESP, then a stray response
      eg_if(32'h108); issue_if(32'h108, '0, 1'b0);
      wait_if_gnt(ok);
      @(posedge clk_i); #3 rst_n_i = 1'b0;
      @(negedge clk_i);
      chk("midreset_outputs", {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
      @(posedge clk_i); #3 rst_n_i = 1'b1; inject_rv = 1'b1;
      @(posedge clk_i); #3 inject_rv = 1'b0;
      @(negedge clk_i);
      chk("stray_rvalid", {if_rvalid_o, dm_rvalid_o, mem_req_o}, 3'b000);
      eg_if(32'h100); issue_if(32'h100, 32'h0000_0013, 1'b1);
      wait_idle();

      chk("leftover_gnt", exp_gnt.size(), 0);
      chk("leftover_if_rsp", exp_if_rd.size(), 0);
      chk("leftover_dm_rsp", exp_dm_rd.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
